// File: rtl/emib_conn_sweep_ctrl.sv
// Purpose: EMIB connectivity sweep; walks a 1 then a 0 over each mapped master pad and checks the mapped slave pad.
// Latency: a mapped pad takes 1 + 2*(SETTLE+1) cycles and an unmapped pad takes 1 cycle; done rises the cycle after the last pad.
// Backpressure: none. start is ignored while busy, map writes are ignored while busy, abort cancels a running sweep.
//
// Ports:
//   clk, rst          sweep clock, asynchronous active-high reset
//   start, abort      one-cycle pulses; abort wins when both arrive together
//   map_wr_*          map table write port; data[IDX_W] = valid, data[IDX_W-1:0] = slave pad index
//   rx_sample         slave pad levels
//   tx_drive, tx_oe   master pad drive and enable (tx_oe is one-hot or zero)
//   busy, done, pass  sweep status; pass is meaningful while done=1
//   err_cnt           saturating error count
//   first_err_*       master pad index of the first failing check
//
// Optional build macro EMIB_SHORT_CHK_EN: the drive-1 check also flags any other
// mapped slave pad that reads 1 (a short). It still counts as one error for that check.

module emib_conn_sweep_ctrl #(
    parameter int NUM_TX = 96,
    parameter int NUM_RX = 102,
    parameter int IDX_W  = 7,
    parameter int SETTLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              map_wr_en,
    input  logic [IDX_W-1:0]  map_wr_addr,
    input  logic [IDX_W:0]    map_wr_data,
    input  logic [NUM_RX-1:0] rx_sample,
    output logic [NUM_TX-1:0] tx_drive,
    output logic [NUM_TX-1:0] tx_oe,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IDX_W:0]    err_cnt,
    output logic              first_err_vld,
    output logic [IDX_W-1:0]  first_err_idx
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_DRV1,
        ST_CHK1,
        ST_DRV0,
        ST_CHK0,
        ST_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_PAD  = IDX_W'(NUM_TX - 1);
    localparam logic [7:0]       SETTLE_M1 = 8'(SETTLE - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    p_q, p_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NUM_TX-1:0]   map_vld_q, map_vld_d;
    logic [IDX_W-1:0]    map_idx_q [NUM_TX];
    logic [IDX_W-1:0]    map_idx_d [NUM_TX];
    logic [NUM_TX-1:0]   tx_drive_q, tx_drive_d;
    logic [NUM_TX-1:0]   tx_oe_q, tx_oe_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [IDX_W:0]      err_cnt_q, err_cnt_d;
    logic                first_err_vld_q, first_err_vld_d;
    logic [IDX_W-1:0]    first_err_idx_q, first_err_idx_d;

    logic [IDX_W-1:0]    exp_idx;
    logic                exp_lvl;
    logic                chk1_bad;
    logic                wr_ok;
    logic                sweeping;

    // Expected slave pad for the pad under test; the write filter keeps it below NUM_RX.
    assign exp_idx  = map_idx_q[p_q];
    assign exp_lvl  = rx_sample[exp_idx];
    assign sweeping = (state_q != ST_IDLE) && (state_q != ST_DONE);

    // Out-of-range pad or slave index drops the whole write, including its valid bit.
    assign wr_ok = map_wr_en && !busy_q
                && (32'(map_wr_addr) < 32'(NUM_TX))
                && (32'(map_wr_data[IDX_W-1:0]) < 32'(NUM_RX));

`ifdef EMIB_SHORT_CHK_EN
    logic [NUM_RX-1:0] rx_used_q, rx_used_d;
    logic [NUM_RX-1:0] exp_onehot;
    logic              short_hit;

    assign exp_onehot = {{(NUM_RX-1){1'b0}}, 1'b1} << exp_idx;
    // Any other slave pad that has ever been mapped and reads high while only one master pad drives is a short.
    assign short_hit  = |(rx_sample & rx_used_q & ~exp_onehot);
    assign chk1_bad   = ~exp_lvl | short_hit;
`else
    assign chk1_bad   = ~exp_lvl;
`endif

    always_comb begin
        logic err_hit;
        logic go_done;

        state_d         = state_q;
        p_d             = p_q;
        cnt_d           = cnt_q;
        map_vld_d       = map_vld_q;
        map_idx_d       = map_idx_q;
        tx_drive_d      = tx_drive_q;
        tx_oe_d         = tx_oe_q;
        busy_d          = busy_q;
        done_d          = done_q;
        pass_d          = pass_q;
        err_cnt_d       = err_cnt_q;
        first_err_vld_d = first_err_vld_q;
        first_err_idx_d = first_err_idx_q;
        err_hit         = 1'b0;
        go_done         = 1'b0;

        if (wr_ok) begin
            map_vld_d[map_wr_addr] = map_wr_data[IDX_W];
            map_idx_d[map_wr_addr] = map_wr_data[IDX_W-1:0];
        end

`ifdef EMIB_SHORT_CHK_EN
        rx_used_d = rx_used_q;
        if (wr_ok && map_wr_data[IDX_W]) begin
            rx_used_d[map_wr_data[IDX_W-1:0]] = 1'b1;
        end
`endif

        // One error at most per check state; a check cancelled by abort does not score.
        if (!abort) begin
            if (state_q == ST_CHK1) err_hit = chk1_bad;
            if (state_q == ST_CHK0) err_hit = exp_lvl;
        end
        if (err_hit) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            if (!first_err_vld_q) begin
                first_err_vld_d = 1'b1;
                first_err_idx_d = p_q;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    state_d         = ST_SEL;
                    p_d             = '0;
                    err_cnt_d       = '0;
                    first_err_vld_d = 1'b0;
                    done_d          = 1'b0;
                    pass_d          = 1'b0;
                    busy_d          = 1'b1;
                end
            end
            ST_SEL: begin
                if (map_vld_q[p_q]) begin
                    // Enable and drive land together with the DRV1 state.
                    state_d           = ST_DRV1;
                    cnt_d             = SETTLE_M1;
                    tx_oe_d           = '0;
                    tx_oe_d[p_q]      = 1'b1;
                    tx_drive_d        = '0;
                    tx_drive_d[p_q]   = 1'b1;
                end else if (p_q == LAST_PAD) begin
                    go_done = 1'b1;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            ST_DRV1: begin
                if (cnt_q == 8'd0) state_d = ST_CHK1;
                else               cnt_d   = cnt_q - 8'd1;
            end
            ST_CHK1: begin
                state_d    = ST_DRV0;
                cnt_d      = SETTLE_M1;
                tx_drive_d = '0;
            end
            ST_DRV0: begin
                if (cnt_q == 8'd0) state_d = ST_CHK0;
                else               cnt_d   = cnt_q - 8'd1;
            end
            ST_CHK0: begin
                tx_oe_d    = '0;
                tx_drive_d = '0;
                if (p_q == LAST_PAD) begin
                    go_done = 1'b1;
                end else begin
                    state_d = ST_SEL;
                    p_d     = p_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // pass uses the count including a possible error from this same final check.
        if (go_done) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
        end

        if (abort && sweeping) begin
            state_d    = ST_IDLE;
            tx_oe_d    = '0;
            tx_drive_d = '0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            pass_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            p_q             <= '0;
            cnt_q           <= '0;
            map_vld_q       <= '0;
            for (int i = 0; i < NUM_TX; i++) begin
                map_idx_q[i] <= '0;
            end
            tx_drive_q      <= '0;
            tx_oe_q         <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            err_cnt_q       <= '0;
            first_err_vld_q <= 1'b0;
            first_err_idx_q <= '0;
`ifdef EMIB_SHORT_CHK_EN
            rx_used_q       <= '0;
`endif
        end else begin
            state_q         <= state_d;
            p_q             <= p_d;
            cnt_q           <= cnt_d;
            map_vld_q       <= map_vld_d;
            map_idx_q       <= map_idx_d;
            tx_drive_q      <= tx_drive_d;
            tx_oe_q         <= tx_oe_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
            err_cnt_q       <= err_cnt_d;
            first_err_vld_q <= first_err_vld_d;
            first_err_idx_q <= first_err_idx_d;
`ifdef EMIB_SHORT_CHK_EN
            rx_used_q       <= rx_used_d;
`endif
        end
    end

    assign tx_drive      = tx_drive_q;
    assign tx_oe         = tx_oe_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_vld = first_err_vld_q;
    assign first_err_idx = first_err_idx_q;

endmodule
